// File: rtl/pio_edge_service_ctrl_if.sv
// PIO Avalon-MM register bus plus the serviced-event stream.
// evt_time is present only with PIO_EDGE_SERVICE_TIMESTAMP_EN.
interface pio_edge_service_ctrl_if;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_edges;
  logic [31:0] evt_data;
`ifdef PIO_EDGE_SERVICE_TIMESTAMP_EN
  logic [31:0] evt_time;

  modport master (
    output pio_address, pio_chipselect,
    output pio_write_n, pio_writedata,
    input  pio_readdata, pio_irq,
    output evt_valid, evt_edges,
    output evt_data, evt_time,
    input  evt_ready
  );

  modport slave (
    input  pio_address, pio_chipselect,
    input  pio_write_n, pio_writedata,
    output pio_readdata, pio_irq,
    input  evt_valid, evt_edges,
    input  evt_data, evt_time,
    output evt_ready
  );
`else
  modport master (
    output pio_address, pio_chipselect,
    output pio_write_n, pio_writedata,
    input  pio_readdata, pio_irq,
    output evt_valid, evt_edges,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  pio_address, pio_chipselect,
    input  pio_write_n, pio_writedata,
    output pio_readdata, pio_irq,
    input  evt_valid, evt_edges,
    input  evt_data,
    output evt_ready
  );
`endif
endinterface

// File: rtl/pio_edge_service_ctrl.sv
// Edge-capture PIO sequencer: mask init, irq service, event stream.
// Optional macro PIO_EDGE_SERVICE_TIMESTAMP_EN adds evt_time.
module pio_edge_service_ctrl #(
  parameter logic [31:0] MASK_INIT = 32'hFFFF_FFFF,
  parameter bit          AUTO_INIT = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  pio_edge_service_ctrl_if.master        bus,
  input  logic [31:0]                    cfg_mask,
  input  logic                           cfg_mask_wr,
  output logic                           busy
);

  typedef enum logic [3:0] {
    S_RST,
    S_INIT,
    S_IDLE,
    S_MASK_WR,
    S_RD_CAP,
    S_RD_DATA,
    S_DATA_LAT,
    S_CLR,
    S_EMIT
  } state_t;

  // S_RST holds the bus quiet while reset is asserted
  localparam state_t S_BOOT = AUTO_INIT ? S_RST : S_IDLE;

  state_t      state;
  state_t      state_nx;
  logic [31:0] mask_q;
  logic        mask_pending;
  logic [31:0] edges_q;
  logic [31:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_BOOT;
      mask_q       <= '0;
      mask_pending <= 1'b0;
      edges_q      <= '0;
      data_q       <= '0;
    end else begin
      state <= state_nx;
      if (cfg_mask_wr) begin
        mask_q       <= cfg_mask;
        mask_pending <= 1'b1;
      end else if (state == S_MASK_WR) begin
        mask_pending <= 1'b0;
      end
      if (state == S_RD_DATA)
        edges_q <= bus.pio_readdata;
      if (state == S_DATA_LAT)
        data_q <= bus.pio_readdata;
    end
  end

  always_comb begin
    state_nx           = state;
    bus.pio_chipselect = 1'b0;
    bus.pio_write_n    = 1'b1;
    bus.pio_address    = 2'd0;
    bus.pio_writedata  = '0;
    bus.evt_valid      = 1'b0;
    unique case (state)
      S_RST: state_nx = S_INIT;
      S_INIT: begin
        bus.pio_chipselect = 1'b1;
        bus.pio_write_n    = 1'b0;
        bus.pio_address    = 2'd2;
        bus.pio_writedata  = MASK_INIT;
        state_nx           = S_IDLE;
      end
      S_IDLE: begin
        if (mask_pending)
          state_nx = S_MASK_WR;
        else if (bus.pio_irq)
          state_nx = S_RD_CAP;
      end
      S_MASK_WR: begin
        bus.pio_chipselect = 1'b1;
        bus.pio_write_n    = 1'b0;
        bus.pio_address    = 2'd2;
        bus.pio_writedata  = mask_q;
        state_nx           = S_IDLE;
      end
      S_RD_CAP: begin
        bus.pio_chipselect = 1'b1;
        bus.pio_address    = 2'd3;
        state_nx           = S_RD_DATA;
      end
      S_RD_DATA: begin
        bus.pio_chipselect = 1'b1;
        bus.pio_address    = 2'd0;
        state_nx           = S_DATA_LAT;
      end
      // nothing captured: spurious irq, skip clear and event
      S_DATA_LAT: state_nx = (edges_q == '0) ? S_IDLE : S_CLR;
      S_CLR: begin
        bus.pio_chipselect = 1'b1;
        bus.pio_write_n    = 1'b0;
        bus.pio_address    = 2'd3;
        bus.pio_writedata  = edges_q;
        state_nx           = S_EMIT;
      end
      S_EMIT: begin
        bus.evt_valid = 1'b1;
        if (bus.evt_ready)
          state_nx = S_IDLE;
      end
      default: state_nx = S_BOOT;
    endcase
  end

  assign bus.evt_edges = edges_q;
  assign bus.evt_data  = data_q;
  assign busy          = (state != S_IDLE);

`ifdef PIO_EDGE_SERVICE_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (state == S_RD_CAP)
        ts_q <= ts_cnt;
    end
  end

  assign bus.evt_time = ts_q;
`endif

endmodule

// File: doc/pio_edge_service_ctrl.md
Name: pio_edge_service_ctrl

Overview:
- Avalon-MM master sequencer that owns one 32-bit edge-capture PIO slave.
- After reset it programs the PIO IRQ mask. On each PIO interrupt it reads the edge-capture register, then the live input data, then clears exactly the captured bits.
- Each serviced interrupt is emitted as one event on a valid/ready stream toward the downstream processing logic. Software and NIOS never touch the PIO directly.

Parameters:
- MASK_INIT, 32'hFFFF_FFFF, IRQ mask written to PIO address 2 after reset.
- AUTO_INIT, 1, 1 = perform the reset-time mask write; 0 = skip INIT and start in IDLE.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- pio_address  out  2  PIO register select: 0 data, 2 irq_mask, 3 edge_capture
- pio_chipselect  out  1  PIO access strobe
- pio_write_n  out  1  active-low write
- pio_writedata  out  32  PIO write data
- pio_readdata  in  32  PIO read data; registered in the PIO, valid 1 cycle after address is driven
- pio_irq  in  1  PIO interrupt (level)
- cfg_mask  in  32  new IRQ mask value
- cfg_mask_wr  in  1  single-cycle request to write cfg_mask to the PIO
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_edges  out  32  edge_capture bits serviced
- evt_data  out  32  input-port value sampled during service
- busy  out  1  FSM not in IDLE

Interface (already decided):
- One clock. Reset is asynchronous and active-low, ports clk and reset_n.

Behaviour:
- Reset values: pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, evt_valid=0, evt_edges=0, evt_data=0, busy=1 if AUTO_INIT else 0, mask_pending=0.
- Reset asserted mid-sequence aborts immediately. Any in-flight event is discarded and the FSM restarts in INIT (or IDLE).

FSM states:
- INIT: one cycle; chipselect=1, write_n=0, address=2, writedata=MASK_INIT. Next state IDLE.
- IDLE: bus idle.
  - If mask_pending: go to MASK_WR (priority over irq).
  - Else if pio_irq=1: go to RD_CAP.
- MASK_WR: one cycle write to address 2 with mask_q. Clears mask_pending (unless a new cfg_mask_wr arrives in this same cycle). Next state IDLE.
- RD_CAP: chipselect=1, write_n=1, address=3.
- RD_DATA: address=0, read. Latches pio_readdata into edges_q at the end of this cycle.
- DATA_LAT: bus idle. Latches pio_readdata into data_q.
  - If edges_q==0 (spurious interrupt or mask race): go to IDLE with no clear and no event.
  - Else: go to CLR.
- CLR: one cycle write to address 3 with writedata=edges_q; clears only the serviced bits.
- EMIT: evt_valid=1, evt_edges=edges_q, evt_data=data_q, held stable until evt_valid&evt_ready. Next state IDLE.

Latency:
- pio_irq sampled high in IDLE at cycle T: RD_CAP T+1, RD_DATA T+2, DATA_LAT T+3, CLR T+4, evt_valid first high T+5.
- Minimum return to IDLE is T+6 with evt_ready=1.

Boundary conditions:
- cfg_mask_wr in any state latches cfg_mask into mask_q and sets mask_pending. Last write wins before service. The mask write is never issued mid-sequence.
- An edge on a bit not in edges_q arriving during service stays captured in the PIO. It re-raises pio_irq and is serviced on the next pass.
- An edge on an already-captured bit arriving before CLR completes is coalesced into the current event. The PIO gives clear priority over a simultaneous edge. This is accepted behaviour.
- Back-pressure: while EMIT stalls, no PIO accesses occur. New edges accumulate in the PIO and are not lost, only coalesced.
- evt_valid never deasserts without a handshake.

Optional Feature:
- Macro PIO_EDGE_SERVICE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running counter is added, reset to 0, incrementing every clk and wrapping at 2^32.
  - Its value is latched in the RD_CAP cycle.
  - It is presented on an extra port evt_time (out, 32) alongside evt_data, with the same stability rules.
- Undefined: no counter, no evt_time port; all other behaviour is identical.

Test Plan:
- Reset release, AUTO_INIT=1, MASK_INIT=32'h0000_00FF -> exactly one write, address=2, data 32'h0000_00FF, in the first cycle after reset; then busy=0.
- PIO bit 3 falling edge with in_port then 32'h0000_0A50 -> read address 3, then read address 0, then write address 3 with 32'h0000_0008; evt_edges=32'h8, evt_data=32'h0A50; evt_valid 5 cycles after irq sampled; pio_irq low after CLR.
- evt_ready held 0 for 20 cycles, bit 5 edge during the stall -> event 1 held stable; bus idle during the stall; a second event follows with evt_edges=32'h20.
- cfg_mask_wr=32'h1 then 32'h3 during a service sequence -> after EMIT exactly one write, address=2, data 32'h3, issued before any new irq service.
- reset_n pulsed low during CLR -> outputs return to reset values asynchronously; INIT mask write repeats; no evt_valid from the aborted sequence.
- Spurious irq (mask cleared between irq and read; edge_capture reads 0) -> no write to address 3, no event, return to IDLE.
